mc_path_gen: RTL and testbench

Monte Carlo asset-path generator sitting directly upstream of the option pricing top level and its MC core. On `start` it emits a discrete price path of `STEPS` 12-bit samples, one per cycle, using LFSR-driven, approximately Gaussian multiplicative increments. On `resend` from the core it replays the identical path, using the same random sequence, so the core can re-read samples it needs again.

---
 rtl/mc_path_gen.sv | 146 ++++++++++++++
 tb/tb_mc_path_gen.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_path_gen.sv
// rtl/mc_path_gen.sv - LFSR-driven Monte Carlo price path generator with replay
module mc_path_gen #(
    parameter int unsigned STEPS     = 16,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned VOL_SHIFT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] s0,
    input  logic        resend,
    output logic [11:0] path,
    output logic        path_valid,
    output logic        path_last,
    output logic        busy
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;
    localparam int KW = $clog2(STEPS);
    localparam logic [KW-1:0] K_LAST = KW'(STEPS - 1);
    localparam logic [KW-1:0] K_PRE  = KW'(STEPS - 2);

    typedef enum logic [1:0] {IDLE, GEN, HOLD} state_t;

    state_t        state, state_nxt;
    logic [15:0]   lfsr, lfsr_nxt, lfsr_snap, snap_nxt;
    logic [11:0]   s0_lat, s0_lat_nxt, path_nxt;
    logic [KW-1:0] k, k_nxt;
    logic          valid_nxt, last_nxt, busy_nxt;

    logic [6:0]         nib_sum;
    logic signed [6:0]  r;
    logic signed [18:0] s_ext, r_ext, prod, delta;
    logic signed [19:0] sum_s;
    logic [11:0]        s_next;
    logic [15:0]        lfsr_adv;

    // The displayed sample is the current S; r comes from the LFSR state shown alongside it.
    assign nib_sum  = 7'(lfsr[3:0]) + 7'(lfsr[7:4]) + 7'(lfsr[11:8]) + 7'(lfsr[15:12]);
    assign r        = $signed(nib_sum - 7'd30);
    assign s_ext    = $signed({7'b0, path});
    assign r_ext    = {{12{r[6]}}, r};
    assign prod     = s_ext * r_ext;
    assign delta    = prod >>> VOL_SHIFT;
    assign sum_s    = $signed({8'b0, path}) + $signed({delta[18], delta});
    assign lfsr_adv = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

    always_comb begin
        s_next = sum_s[11:0];
        if (sum_s < 20'sd1)
            s_next = 12'd1;
        else if (sum_s > 20'sd4095)
            s_next = 12'd4095;
    end

    always_comb begin
        state_nxt  = state;
        lfsr_nxt   = lfsr;
        snap_nxt   = lfsr_snap;
        s0_lat_nxt = s0_lat;
        path_nxt   = path;
        k_nxt      = k;
        valid_nxt  = 1'b0;
        last_nxt   = 1'b0;
        busy_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    s0_lat_nxt = s0;
                    snap_nxt   = lfsr;
                    path_nxt   = s0;
                    k_nxt      = '0;
                    valid_nxt  = 1'b1;
                    busy_nxt   = 1'b1;
                    state_nxt  = GEN;
                end
            end
            GEN: begin
                if (resend) begin
                    lfsr_nxt  = lfsr_snap;
                    path_nxt  = s0_lat;
                    k_nxt     = '0;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end else begin
                    lfsr_nxt = lfsr_adv;
                    if (k == K_LAST) begin
                        k_nxt     = '0;
                        state_nxt = HOLD;
                    end else begin
                        path_nxt  = s_next;
                        k_nxt     = k + 1'b1;
                        valid_nxt = 1'b1;
                        busy_nxt  = 1'b1;
                        last_nxt  = (k == K_PRE);
                    end
                end
            end
            HOLD: begin
                // Replay beats a new path when both arrive together.
                if (resend) begin
                    lfsr_nxt  = lfsr_snap;
                    path_nxt  = s0_lat;
                    k_nxt     = '0;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = GEN;
                end else if (start) begin
                    s0_lat_nxt = s0;
                    snap_nxt   = lfsr;
                    path_nxt   = s0;
                    k_nxt      = '0;
                    valid_nxt  = 1'b1;
                    busy_nxt   = 1'b1;
                    state_nxt  = GEN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= SEED_EFF;
            lfsr_snap  <= SEED_EFF;
            s0_lat     <= '0;
            path       <= '0;
            k          <= '0;
            path_valid <= 1'b0;
            path_last  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            lfsr       <= lfsr_nxt;
            lfsr_snap  <= snap_nxt;
            s0_lat     <= s0_lat_nxt;
            path       <= path_nxt;
            k          <= k_nxt;
            path_valid <= valid_nxt;
            path_last  <= last_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_mc_path_gen.sv
// tb/tb_mc_path_gen.sv - self-checking bench for mc_path_gen with a path scoreboard
module tb_mc_path_gen;

    localparam int          STEPS     = 16;
    localparam logic [15:0] SEED      = 16'hACE1;
    localparam int          VOL_SHIFT = 8;

    logic        clk = 1'b0;
    logic        rst, start, resend;
    logic [11:0] s0, path;
    logic        path_valid, path_last, busy;

    typedef struct packed {
        logic [11:0] val;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] m_lfsr, m_snap;
    logic [11:0] m_s0lat;
    logic [11:0] first_pass[STEPS];
    logic [11:0] got[STEPS];

    mc_path_gen #(.STEPS(STEPS), .SEED(SEED), .VOL_SHIFT(VOL_SHIFT)) dut (
        .clk(clk), .rst(rst), .start(start), .s0(s0), .resend(resend),
        .path(path), .path_valid(path_valid), .path_last(path_last), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] m_adv(input logic [15:0] l);
        logic [15:0] n;
        n = l >> 1;
        if (l[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic logic [11:0] m_step(input logic [11:0] s, input logic [15:0] l);
        int rr, d, n;
        rr = int'(l[3:0]) + int'(l[7:4]) + int'(l[11:8]) + int'(l[15:12]) - 30;
        d  = (int'(s) * rr) >>> VOL_SHIFT;
        n  = int'(s) + d;
        if (n < 1) n = 1;
        if (n > 4095) n = 4095;
        return n[11:0];
    endfunction

    task automatic push_path(input logic [11:0] sv);
        logic [11:0] s;
        logic [15:0] l;
        s = sv;
        l = m_lfsr;
        for (int i = 0; i < STEPS; i++) begin
            exp_q.push_back('{val: s, last: (i == STEPS - 1)});
            s = m_step(s, l);
            l = m_adv(l);
        end
        m_lfsr = l;
    endtask

    task automatic model_start(input logic [11:0] v);
        m_s0lat = v;
        m_snap  = m_lfsr;
        push_path(v);
    endtask

    task automatic model_resend;
        exp_q.delete();
        m_lfsr = m_snap;
        push_path(m_s0lat);
    endtask

    task automatic model_reset;
        exp_q.delete();
        m_lfsr  = SEED;
        m_snap  = SEED;
        m_s0lat = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; resend = 1'b0; s0 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({path, path_valid, path_last, busy} !== 15'd0) begin
            failures++;
            $display("FAIL reset_values got path=%0d v=%b l=%b b=%b want all 0", path, path_valid, path_last, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1; s0 = 12'd700; model_start(12'd700);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || path_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_gen got busy=%b valid=%b want 1 1", busy, path_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({path, path_valid, path_last, busy} !== 15'd0) begin
            failures++;
            $display("FAIL reset_async got path=%0d v=%b l=%b b=%b want all 0", path, path_valid, path_last, busy);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || path_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%b valid=%b want 0 0", busy, path_valid);
        end
    endtask

    task automatic test_basic;
        exp_t        e;
        int          nvalid = 0;
        int          nlast = 0;
        logic [11:0] last_exp = '0;
        start = 1'b1; s0 = 12'd2048; model_start(12'd2048);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < STEPS + 3; c++) begin
            if (path_valid === 1'b1) begin
                if (nvalid < STEPS) first_pass[nvalid] = path;
                nvalid++;
                if (path_last === 1'b1) nlast++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL basic_extra got sample %0d want none", path);
                end else begin
                    e = exp_q.pop_front();
                    last_exp = e.val;
                    if (path !== e.val || path_last !== e.last) begin
                        failures++;
                        $display("FAIL basic_sample got %0d/%b want %0d/%b", path, path_last, e.val, e.last);
                    end
                end
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_busy got %b want 1", busy);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (first_pass[0] !== 12'd2048 || first_pass[1] !== 12'd2104) begin
            failures++;
            $display("FAIL basic_first_two got %0d,%0d want 2048,2104", first_pass[0], first_pass[1]);
        end
        checks++;
        if (nvalid != STEPS || nlast != 1) begin
            failures++;
            $display("FAIL basic_counts got valid=%0d last=%0d want %0d 1", nvalid, nlast, STEPS);
        end
        checks++;
        if (busy !== 1'b0 || path_valid !== 1'b0 || path !== last_exp) begin
            failures++;
            $display("FAIL basic_hold got busy=%b v=%b path=%0d want 0 0 %0d", busy, path_valid, path, last_exp);
        end
    endtask

    task automatic test_replay;
        exp_t e;
        int   idx = 0;
        int   ndiff = 0;
        resend = 1'b1; model_resend();
        @(negedge clk);
        resend = 1'b0;
        for (int c = 0; c < STEPS + 3; c++) begin
            if (path_valid === 1'b1) begin
                checks++;
                if (idx >= STEPS || path !== first_pass[idx]) begin
                    failures++;
                    $display("FAIL replay_match idx=%0d got %0d want first pass value", idx, path);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (path !== e.val || path_last !== e.last) begin
                        failures++;
                        $display("FAIL replay_sample got %0d/%b want %0d/%b", path, path_last, e.val, e.last);
                    end
                end
                idx++;
            end
            @(negedge clk);
        end
        checks++;
        if (idx != STEPS || exp_q.size() != 0) begin
            failures++;
            $display("FAIL replay_count got %0d left=%0d want %0d 0", idx, exp_q.size(), STEPS);
        end
        start = 1'b1; s0 = 12'd2048; model_start(12'd2048);
        @(negedge clk);
        start = 1'b0;
        idx = 0;
        for (int c = 0; c < STEPS + 3; c++) begin
            if (path_valid === 1'b1) begin
                if (idx < STEPS && path !== first_pass[idx]) ndiff++;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (path !== e.val || path_last !== e.last) begin
                        failures++;
                        $display("FAIL second_sample got %0d/%b want %0d/%b", path, path_last, e.val, e.last);
                    end
                end
                idx++;
            end
            @(negedge clk);
        end
        checks++;
        if (ndiff == 0 || idx != STEPS) begin
            failures++;
            $display("FAIL second_differs got diffs=%0d samples=%0d want >0 %0d", ndiff, idx, STEPS);
        end
    endtask

    task automatic test_saturation;
        exp_t e;
        int   idx = 0;
        rst = 1'b1; model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b1; s0 = 12'd4095; model_start(12'd4095);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < STEPS + 3; c++) begin
            if (path_valid === 1'b1) begin
                if (idx < STEPS) got[idx] = path;
                idx++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sat_hi_extra got %0d want none", path);
                end else begin
                    e = exp_q.pop_front();
                    if (path !== e.val || path_last !== e.last) begin
                        failures++;
                        $display("FAIL sat_hi_sample got %0d/%b want %0d/%b", path, path_last, e.val, e.last);
                    end
                end
            end
            @(negedge clk);
        end
        checks++;
        if (got[1] !== 12'd4095) begin
            failures++;
            $display("FAIL sat_hi got %0d want 4095", got[1]);
        end
        start = 1'b1; s0 = 12'd1; model_start(12'd1);
        @(negedge clk);
        start = 1'b0;
        idx = 0;
        for (int c = 0; c < STEPS + 3; c++) begin
            if (path_valid === 1'b1) begin
                idx++;
                checks++;
                if (path !== 12'd1) begin
                    failures++;
                    $display("FAIL sat_lo got %0d want 1", path);
                end
                if (exp_q.size() != 0) e = exp_q.pop_front();
            end
            @(negedge clk);
        end
        checks++;
        if (idx != STEPS) begin
            failures++;
            $display("FAIL sat_lo_count got %0d want %0d", idx, STEPS);
        end
    endtask

    task automatic test_collisions;
        exp_t e;
        int   idx = 0;
        start = 1'b1; s0 = 12'd1000; model_start(12'd1000);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < STEPS + 3; c++) begin
            start = 1'b0;
            if (path_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL coll_extra got %0d want none", path);
                end else begin
                    e = exp_q.pop_front();
                    if (path !== e.val || path_last !== e.last) begin
                        failures++;
                        $display("FAIL coll_sample idx=%0d got %0d/%b want %0d/%b", idx, path, path_last, e.val, e.last);
                    end
                end
                if (idx == 5) begin
                    start = 1'b1;
                    s0 = 12'd500;
                end
                idx++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (idx != STEPS) begin
            failures++;
            $display("FAIL coll_count got %0d want %0d", idx, STEPS);
        end
        start = 1'b1; resend = 1'b1; s0 = 12'd300; model_resend();
        @(negedge clk);
        start = 1'b0; resend = 1'b0;
        checks++;
        if (path_valid !== 1'b1 || path !== 12'd1000) begin
            failures++;
            $display("FAIL coll_both got v=%b path=%0d want 1 1000", path_valid, path);
        end
        idx = 0;
        for (int c = 0; c < STEPS + 3; c++) begin
            if (path_valid === 1'b1) begin
                idx++;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (path !== e.val || path_last !== e.last) begin
                        failures++;
                        $display("FAIL coll_both_sample got %0d/%b want %0d/%b", path, path_last, e.val, e.last);
                    end
                end
            end
            @(negedge clk);
        end
        checks++;
        if (idx != STEPS) begin
            failures++;
            $display("FAIL coll_both_count got %0d want %0d", idx, STEPS);
        end
        rst = 1'b1; model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        resend = 1'b1;
        @(negedge clk);
        resend = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (path_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL idle_resend got v=%b busy=%b want 0 0", path_valid, busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_midpath_resend;
        exp_t e;
        int   idx = 0;
        int   total = 0;
        logic aborted = 1'b0;
        logic just = 1'b0;
        start = 1'b1; s0 = 12'd3000; model_start(12'd3000);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2 * STEPS + 4; c++) begin
            resend = 1'b0;
            if (just) begin
                just = 1'b0;
                checks++;
                if (path_valid !== 1'b1 || path !== 12'd3000) begin
                    failures++;
                    $display("FAIL mid_first got v=%b path=%0d want 1 3000", path_valid, path);
                end
            end
            if (path_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL mid_extra got %0d want none", path);
                end else begin
                    e = exp_q.pop_front();
                    if (path !== e.val || path_last !== e.last) begin
                        failures++;
                        $display("FAIL mid_sample got %0d/%b want %0d/%b", path, path_last, e.val, e.last);
                    end
                end
                if (idx == 7 && !aborted) begin
                    aborted = 1'b1;
                    just = 1'b1;
                    resend = 1'b1;
                    model_resend();
                    idx = 0;
                end else begin
                    idx++;
                end
                total++;
            end
            @(negedge clk);
        end
        resend = 1'b0;
        checks++;
        if (total != 8 + STEPS || exp_q.size() != 0) begin
            failures++;
            $display("FAIL mid_count got %0d left=%0d want %0d 0", total, exp_q.size(), 8 + STEPS);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_replay();
        test_saturation();
        test_collisions();
        test_midpath_resend();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
